// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    FLUSH       = 2'd2,
    MEM_WAIT    = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_if.sv
// Decode/execute hazard fields in, stall/clear controls and perf counters out.
interface hazard_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             ifid_clear;
  logic             idex_clear;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Datapath side: supplies stage fields, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_branch_taken, mem_busy,
    input  pc_stall, ifid_stall, idex_stall, ifid_clear, idex_clear,
           stall_count, flush_count
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_branch_taken, mem_busy,
    output pc_stall, ifid_stall, idex_stall, ifid_clear, idex_clear,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only while below the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stalls for load-use and memory waits,
// registered single-cycle clear pulses for bubbles and branch flushes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = hazard_pkg::REG_W
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hif
);

  state_e     state_q;
  state_e     state_d;
  logic       ifid_clear_q;
  logic       ifid_clear_d;
  logic       idex_clear_q;
  logic       idex_clear_d;
  logic [REG_W-1:0] rd;
  logic       hz;
  logic       flush_inc;

  assign rd = hif.ex_rd;

  // Load-use hazard; a load to x0 never stalls.
  always_comb begin
    hz = hif.ex_is_load && (rd != '0) &&
         ((hif.id_uses_rs1 && (hif.id_rs1 == rd)) ||
          (hif.id_uses_rs2 && (hif.id_rs2 == rd)));
  end

  // Next state, Mealy stalls and the clear pulses scheduled for next cycle.
  always_comb begin
    state_d        = state_q;
    hif.pc_stall   = 1'b0;
    hif.ifid_stall = 1'b0;
    hif.idex_stall = 1'b0;
    unique case (state_q)
      // Once memory is ready, MEM_WAIT resolves the current inputs exactly as RUN.
      RUN, MEM_WAIT: begin
        if (hif.mem_busy) begin
          hif.pc_stall   = 1'b1;
          hif.ifid_stall = 1'b1;
          hif.idex_stall = 1'b1;
          state_d        = MEM_WAIT;
        end else if (hif.ex_branch_taken) begin
          state_d = FLUSH;
        end else if (hz) begin
          hif.pc_stall   = 1'b1;
          hif.ifid_stall = 1'b1;
          state_d        = LOAD_BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      // EX holds a bubble or squashed op: only memory wait matters.
      LOAD_BUBBLE, FLUSH: begin
        if (hif.mem_busy) begin
          hif.pc_stall   = 1'b1;
          hif.ifid_stall = 1'b1;
          hif.idex_stall = 1'b1;
          state_d        = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
    endcase
    if (reset) begin
      hif.pc_stall   = 1'b0;
      hif.ifid_stall = 1'b0;
      hif.idex_stall = 1'b0;
      state_d        = RUN;
    end
    ifid_clear_d = (state_d == FLUSH);
    idex_clear_d = (state_d == FLUSH) || (state_d == LOAD_BUBBLE);
    flush_inc    = (state_d == FLUSH);
  end

  // State and clear-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ifid_clear_q <= 1'b0;
      idex_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_clear_q <= ifid_clear_d;
      idex_clear_q <= idex_clear_d;
    end
  end

  assign hif.ifid_clear = ifid_clear_q;
  assign hif.idex_clear = idex_clear_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hif.pc_stall),
    .count (hif.stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (hif.flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: driver predicts each cycle's outputs from a stateless
// rule model, monitor compares two DUTs (wide and 2-bit counters).
module tb_hazard_ctrl;

  logic clk;
  logic reset;

  hazard_if #(.REG_W(5), .CNT_W(16)) a_if ();
  hazard_if #(.REG_W(5), .CNT_W(2))  b_if ();

  hazard_ctrl #(.CNT_W(16), .REG_W(5)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .hif   (a_if)
  );

  hazard_ctrl #(.CNT_W(2), .REG_W(5)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .hif   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit pc;
    bit ifid;
    bit idex;
    bit ifid_clr;
    bit idex_clr;
    int stall_cnt;
    int flush_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: clears visible this cycle, unbounded event counts.
  bit   m_ifid_clr = 0;
  bit   m_idex_clr = 0;
  int   m_stall    = 0;
  int   m_flush    = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // One cycle of stimulus applied to both DUTs, plus its predicted response.
  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic ld, input logic br, input logic busy,
                     input logic rst);
    exp_t e;
    bit   hz;
    bit   ignore;
    bit   n_ifid;
    bit   n_idex;
    @(posedge clk);
    #1;
    reset = rst;
    a_if.id_rs1 = rs1; a_if.id_rs2 = rs2; a_if.id_uses_rs1 = u1;
    a_if.id_uses_rs2 = u2; a_if.ex_rd = rd; a_if.ex_is_load = ld;
    a_if.ex_branch_taken = br; a_if.mem_busy = busy;
    b_if.id_rs1 = rs1; b_if.id_rs2 = rs2; b_if.id_uses_rs1 = u1;
    b_if.id_uses_rs2 = u2; b_if.ex_rd = rd; b_if.ex_is_load = ld;
    b_if.ex_branch_taken = br; b_if.mem_busy = busy;

    hz = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // While a clear pulse is out, EX holds a nop so branch/hazard are moot.
    ignore = m_ifid_clr || m_idex_clr;
    e.ifid_clr  = m_ifid_clr;
    e.idex_clr  = m_idex_clr;
    e.stall_cnt = m_stall;
    e.flush_cnt = m_flush;
    e.pc = 0; e.ifid = 0; e.idex = 0;
    n_ifid = 0; n_idex = 0;
    if (rst) begin
      // everything quiet
    end else if (busy) begin
      e.pc = 1; e.ifid = 1; e.idex = 1;
    end else if (!ignore) begin
      if (br) begin
        n_ifid = 1; n_idex = 1;
        m_flush++;
      end else if (hz) begin
        e.pc = 1; e.ifid = 1;
        n_idex = 1;
      end
    end
    sb.push_back(e);
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else if (e.pc) begin
      m_stall++;
    end
    m_ifid_clr = n_ifid;
    m_idex_clr = n_idex;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUTs present a response, check it against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_stall",      int'(a_if.pc_stall),   int'(e.pc));
        chk("ifid_stall",    int'(a_if.ifid_stall), int'(e.ifid));
        chk("idex_stall",    int'(a_if.idex_stall), int'(e.idex));
        chk("ifid_clear",    int'(a_if.ifid_clear), int'(e.ifid_clr));
        chk("idex_clear",    int'(a_if.idex_clear), int'(e.idex_clr));
        chk("stall_count",   int'(a_if.stall_count), sat(e.stall_cnt, 16));
        chk("flush_count",   int'(a_if.flush_count), sat(e.flush_cnt, 16));
        chk("b_pc_stall",    int'(b_if.pc_stall),   int'(e.pc));
        chk("b_idex_clear",  int'(b_if.idex_clear), int'(e.idex_clr));
        chk("b_stall_count", int'(b_if.stall_count), sat(e.stall_cnt, 2));
        chk("b_flush_count", int'(b_if.flush_count), sat(e.flush_cnt, 2));
      end
    end
  end

  // Driver: directed scenarios, then random traffic.
  initial begin
    int wait_cnt;
    reset = 1'b1;
    a_if.id_rs1 = '0; a_if.id_rs2 = '0; a_if.id_uses_rs1 = 0; a_if.id_uses_rs2 = 0;
    a_if.ex_rd = '0; a_if.ex_is_load = 0; a_if.ex_branch_taken = 0; a_if.mem_busy = 0;
    b_if.id_rs1 = '0; b_if.id_rs2 = '0; b_if.id_uses_rs1 = 0; b_if.id_uses_rs2 = 0;
    b_if.ex_rd = '0; b_if.ex_is_load = 0; b_if.ex_branch_taken = 0; b_if.mem_busy = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use on rs1
    cyc(5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle(3);
    // load-use on rs2
    cyc(1, 7, 1, 1, 7, 1, 0, 0, 0);
    idle(2);
    // x0 guard
    cyc(0, 0, 1, 1, 0, 1, 0, 0, 0);
    idle(2);
    // branch held two cycles
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // memory wait with a hazard pending underneath
    for (int i = 0; i < 3; i++) cyc(5, 0, 1, 0, 5, 1, 0, 1, 0);
    cyc(5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle(3);
    // busy and branch together, then branch alone
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // reset lands on the cycle that would schedule a flush
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    // reset on the cycle that would schedule a load bubble
    cyc(3, 0, 1, 0, 3, 1, 0, 0, 1);
    idle(2);
    // drive the narrow counters past saturation
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
    end

    for (int i = 0; i < 1500; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 59) == 0));
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 5) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d responses unchecked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that produces the stall and clear (bubble) signals consumed by the pipeline_register stages: PC, IF/ID, ID/EX.
- Detects load-use hazards, taken-branch flushes and data-memory wait states; sequences bubbles so every clear is a clean single-cycle pulse.
- Sits beside the datapath, fed by decode (ID) and execute (EX) stage fields.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count performance counters.
- REG_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  REG_W  rs1 index of the instruction in ID.
- id_rs2  in  REG_W  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination index of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- pc_stall  out  1  hold PC (combinational, Mealy).
- ifid_stall  out  1  hold IF/ID (combinational, Mealy).
- idex_stall  out  1  hold ID/EX (combinational, Mealy).
- ifid_clear  out  1  registered one-cycle pulse that loads a nop into IF/ID.
- idex_clear  out  1  registered one-cycle pulse that loads a nop into ID/EX.
- stall_count  out  CNT_W  saturating count of cycles with pc_stall high.
- flush_count  out  CNT_W  saturating count of branch flushes issued.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset:
  - state=RUN.
  - ifid_clear=idex_clear=0; counters=0.
  - Stall outputs are 0 while reset is high.
  - Reset mid-stall or mid-flush aborts it; no pending pulse survives.
- Load-use hazard (hz): ex_is_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - rd==x0 never raises a hazard, so nops never trigger stalls or forwarding.
- States: RUN, LOAD_BUBBLE, FLUSH, MEM_WAIT.
- Priority in RUN: mem_busy > ex_branch_taken > hz.
- RUN:
  - mem_busy: all three stalls=1 this cycle; next state MEM_WAIT.
  - Else ex_branch_taken: no stall; next cycle ifid_clear=idex_clear=1; flush_count+1; next state FLUSH.
  - Else hz: pc_stall=ifid_stall=1, idex_stall=0; next cycle idex_clear=1; next state LOAD_BUBBLE.
  - Else: all outputs 0.
- LOAD_BUBBLE:
  - Clear pulse is high; stalls are 0 unless mem_busy.
  - mem_busy: all stalls=1 and next state MEM_WAIT; the clear pulse still ends after 1 cycle.
  - Otherwise next state RUN.
  - Branch and hazard inputs are ignored, because EX holds the bubble.
- FLUSH:
  - Clear pulses are high; branch and hazard inputs are ignored, because EX holds a squashed instruction.
  - Next state RUN, or MEM_WAIT with all stalls=1 if mem_busy.
- MEM_WAIT:
  - All stalls=1 while mem_busy; all other inputs ignored.
  - When mem_busy drops: stalls=0 that cycle and the RUN rules apply to the current inputs (Mealy); the state transitions as RUN would.
- Clear pulse rules:
  - Each clear is exactly 1 cycle high.
  - A clear is never high on two consecutive cycles; the FLUSH and LOAD_BUBBLE states guarantee this, since consumers act on the clear edge.
- Counters:
  - stall_count increments on every cycle with pc_stall=1.
  - Both counters saturate at all-ones and never wrap.
- Latency:
  - Stall outputs: 0 cycles (combinational from state and inputs).
  - Clear outputs: 1 cycle after the triggering condition is sampled.

Decomposition:
- Shared package hazard_pkg: state encoding localparams (RUN=2'd0, LOAD_BUBBLE=2'd1, FLUSH=2'd2, MEM_WAIT=2'd3) and REG_W.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count, saturating), instantiated twice.

Test Plan:
- Load-use on rs1: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall=ifid_stall=1 the same cycle; idex_clear=1 for exactly the next cycle; stall_count=1.
- x0 guard: ex_is_load=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall, no clear, stall_count stays 0.
- Branch flush: ex_branch_taken=1 for 2 consecutive cycles -> ifid_clear=idex_clear=1 for 1 cycle only, then 0; flush_count=1.
- Memory wait: mem_busy=1 for 3 cycles with hz also true -> stalls high 3 cycles, no clear; on mem_busy=0 stalls drop to 1-cycle load-use stall, then idex_clear pulse; stall_count=4.
- Simultaneous events: mem_busy=1 and ex_branch_taken=1 in RUN -> stall wins; when mem_busy falls with branch still high -> flush pulse next cycle.
- Reset mid-flush and saturation: assert reset the cycle a clear is scheduled -> clear stays 0, state RUN; with CNT_W=2, 5 stall cycles -> stall_count=3.
